axil_master_arbiter: RTL and testbench
======================================

Name: axil_master_arbiter

Overview:
Shares one AXI-Lite master port between NUM_REQ local requesters using round-robin arbitration. It sequences each single-beat read or write on the AW/W/B or AR/R channels. It sits in front of the s3_axi slave wrapper and drives the s3_axi_* slave ports directly. Only one transaction is outstanding at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, AXI data width
ADDR_WIDTH, 8, AXI address width
RESP_WIDTH, 3, response field width, matching the slave wrapper

Ports:
s3_axi_aclk  in  1  single clock, rising edge
s3_axi_areset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester transaction request, held until req_ready
req_write  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*(DATA_WIDTH/8)  packed byte strobes
req_ready  out  NUM_REQ  one-hot, 1-cycle pulse when request is captured
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse when the transaction completes
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes
rsp_resp  out  RESP_WIDTH  bresp or rresp, valid with rsp_valid
m_axi_awaddr / m_axi_awvalid  out  ADDR_WIDTH / 1  write address channel
m_axi_awready  in  1
m_axi_wdata / m_axi_wstrb / m_axi_wvalid  out  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel
m_axi_wready  in  1
m_axi_bresp / m_axi_bvalid  in  RESP_WIDTH / 1  write response channel
m_axi_bready  out  1
m_axi_araddr / m_axi_arvalid  out  ADDR_WIDTH / 1  read address channel
m_axi_arready  in  1
m_axi_rdata / m_axi_rresp / m_axi_rvalid  in  DATA_WIDTH / RESP_WIDTH / 1  read data channel
m_axi_rready  out  1

Behaviour:
- Reset (asynchronous, immediate):
  - all valid/ready outputs, req_ready, rsp_valid, rsp_rdata, rsp_resp, and address/data registers are 0.
  - State is IDLE; last-grant pointer is NUM_REQ-1, so requester 0 wins first.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning upward from last+1, wrapping modulo NUM_REQ.
  - Register its addr/wdata/wstrb/write, pulse req_ready[grant] that same cycle, and update last.
  - Next state is WR or RD_ADDR.
- WR:
  - awvalid and wvalid both rise the cycle after capture.
  - Each drops independently on the cycle after its own handshake (valid & ready).
  - Leave for WR_RESP when both handshakes are done, including the same-cycle case.
  - awaddr/wdata/wstrb stay stable while their valid is high.
- WR_RESP: bready = 1; on bvalid, latch bresp, set rdata latch to 0, go to DONE.
- RD_ADDR: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1; on rvalid, latch rdata/rresp, go to DONE.
- DONE: rsp_valid[grant] = 1 for exactly one cycle with the latched data/resp, then return to IDLE.
- Latency: with zero-wait slave readies, capture to rsp_valid is 3 cycles for both writes and reads. A new grant is possible the cycle after DONE.
- Requests arriving while busy are held by the requester; req_ready never pulses outside IDLE.
- Response codes are passed through unmodified; no retry.
- Dropping req_valid before req_ready is legal: no grant occurs.
- No AXI valid deasserts before its handshake, except on reset.

Test Plan:
- req0 write addr 0x00, data 25, wstrb 0xF -> awaddr=0, wdata=25, wstrb=0xF on the bus; rsp_valid=2'b01, rsp_resp=0, rsp_rdata=0.
- req1 read addr 0x00 after the previous write -> araddr=0; rsp_valid=2'b10, rsp_rdata=25.
- req0 and req1 both valid, repeated 4 times back-to-back -> grant order 0,1,0,1; no double-issue.
- Slave holds awready low 3 cycles while wready=1 immediately -> wvalid drops after 1 cycle; awvalid stays high with stable awaddr=0x04 until accepted; a single B follows.
- Slave returns bresp=3'b010 on write to 0x08 -> rsp_resp=3'b010 forwarded to that requester.
- Assert reset during RD_DATA (rvalid not yet seen) -> arvalid/rready/rsp_valid are 0 immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite master port between NUM_REQ requesters.
// Only one single-beat read or write is in flight at a time.
module axil_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                              s3_axi_aclk,
  input  logic                              s3_axi_areset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic [RESP_WIDTH-1:0]             rsp_resp,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [RESP_WIDTH-1:0]             m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [RESP_WIDTH-1:0]             m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_RST = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE_OH   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    bready_q, bready_d;
  logic                    rready_q, rready_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [RESP_WIDTH-1:0]   rsp_resp_q, rsp_resp_d;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [IDX_WIDTH-1:0]    grant_s;
  logic                    found_s;

  // Round-robin pick: first pending requester after the last one granted.
  always_comb begin
    logic [IDX_WIDTH-1:0] idx_v;
    grant_s = last_q;
    found_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_v = IDX_WIDTH'((int'(last_q) + i) % NUM_REQ);
      if (!found_s && req_valid[idx_v]) begin
        found_s = 1'b1;
        grant_s = idx_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Transaction sequencer: next state and next register values.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    req_ready_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          req_ready_s = ONE_OH << grant_s;
          last_d      = grant_s;
          addr_d      = req_addr[int'(grant_s)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = req_wdata[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d     = req_wstrb[int'(grant_s)*STRB_WIDTH +: STRB_WIDTH];
          if (req_write[grant_s]) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        // AW and W complete independently; leave once neither is still pending.
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          state_d = ST_WR_RESP;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = ONE_OH << last_q;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          rsp_valid_d = ONE_OH << last_q;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase
    bready_d = (state_d == ST_WR_RESP);
    rready_d = (state_d == ST_RD_DATA);
  end

  // State and output registers.
  always_ff @(posedge s3_axi_aclk or posedge s3_axi_areset) begin
    if (s3_axi_areset) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RST;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready     = req_ready_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Randomised bench for axil_master_arbiter: requester queues, a memory-backed
// AXI-Lite slave and a queue-level round-robin reference model.
module tb_axil_master_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata;
  logic [RW-1:0]   rsp_resp;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic [RW-1:0]   m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic            m_axi_rvalid, m_axi_rready;

  axil_master_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
    .s3_axi_aclk(clk), .s3_axi_areset(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } txn_t;

  txn_t txq [N][$];

  // observation logs
  int            grant_log[$], grant_cyc[$], rsp_id[$], rsp_cyc[$];
  logic [DW-1:0] rsp_dat[$];
  logic [RW-1:0] rsp_rsp[$];
  logic [AW-1:0] bw_addr[$], br_addr[$];
  logic [DW-1:0] bw_data[$];
  logic [SW-1:0] bw_strb[$];
  int            viol = 0, aw_hi = 0, w_hi = 0, instab = 0;

  // expectations
  int            exp_id[$];
  logic [DW-1:0] exp_dat[$];
  logic [RW-1:0] exp_rsp[$];
  logic [AW-1:0] ew_addr[$], er_addr[$];
  logic [DW-1:0] ew_data[$];
  logic [SW-1:0] ew_strb[$];
  logic [DW-1:0] ref_mem [256];
  int            ref_last;

  int            aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [RW-1:0] slave_bresp = 3'b000;
  int            n_checks = 0, n_fail = 0;

  // requester side: present queue heads, pop after capture, log grants/responses
  initial begin
    logic [N-1:0] granted;
    granted = '0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        granted = '0;
        req_valid = '0;
      end else begin
        for (int i = 0; i < N; i++)
          if (granted[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        for (int i = 0; i < N; i++) begin
          if (txq[i].size() > 0) begin
            req_valid[i] = 1'b1;
            req_write[i] = txq[i][0].wr;
            req_addr[i*AW +: AW] = txq[i][0].addr;
            req_wdata[i*DW +: DW] = txq[i][0].data;
            req_wstrb[i*SW +: SW] = txq[i][0].strb;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
        #1;
        granted = req_ready;
        if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) viol++;
        for (int i = 0; i < N; i++)
          if (req_ready[i]) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
        if (rsp_valid != '0) begin
          if ($countones(rsp_valid) != 1) viol++;
          for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_id.push_back(i);
          rsp_dat.push_back(rsp_rdata);
          rsp_rsp.push_back(rsp_resp);
          rsp_cyc.push_back(cyc);
        end
      end
    end
  end

  // memory-backed AXI-Lite slave with programmable ready/response delays
  initial begin
    logic [DW-1:0] smem [256];
    logic [DW-1:0] w_d, mask;
    logic [AW-1:0] aw_a, ar_a, aw_prev_a;
    logic [SW-1:0] w_s;
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_have, w_have, r_pend, aw_prev_v;
    int aw_cnt, w_cnt, r_cnt;
    for (int i = 0; i < 256; i++) smem[i] = '0;
    {hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_have, w_have, r_pend, aw_prev_v} = '0;
    aw_cnt = 0; w_cnt = 0; r_cnt = 0; aw_a = '0; ar_a = '0; aw_prev_a = '0; w_d = '0; w_s = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_have, w_have, r_pend, aw_prev_v} = '0;
        aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
      end else begin
        if (hs_b) m_axi_bvalid = 1'b0;
        if (hs_r) m_axi_rvalid = 1'b0;
        if (hs_aw) aw_have = 1'b1;
        if (hs_w) w_have = 1'b1;
        if (aw_have && w_have) begin
          mask = {{8{w_s[3]}}, {8{w_s[2]}}, {8{w_s[1]}}, {8{w_s[0]}}};
          smem[aw_a] = (smem[aw_a] & ~mask) | (w_d & mask);
          bw_addr.push_back(aw_a); bw_data.push_back(w_d); bw_strb.push_back(w_s);
          m_axi_bvalid = 1'b1; m_axi_bresp = slave_bresp;
          aw_have = 1'b0; w_have = 1'b0;
        end
        if (hs_ar) begin r_pend = 1'b1; r_cnt = 0; br_addr.push_back(ar_a); end
        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = smem[ar_a]; m_axi_rresp = 3'b000; r_pend = 1'b0;
          end else r_cnt++;
        end
        if (m_axi_awvalid) begin
          aw_hi++;
          if (aw_prev_v && aw_prev_a !== m_axi_awaddr) instab++;
        end
        if (m_axi_wvalid) w_hi++;
        aw_prev_v = m_axi_awvalid; aw_prev_a = m_axi_awaddr;
        m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
        if (m_axi_awvalid && !m_axi_awready) aw_cnt++; else aw_cnt = 0;
        m_axi_wready = m_axi_wvalid && (w_cnt >= w_delay);
        if (m_axi_wvalid && !m_axi_wready) w_cnt++; else w_cnt = 0;
        m_axi_arready = m_axi_arvalid;
        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid && m_axi_wready;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_b  = m_axi_bvalid && m_axi_bready;
        hs_r  = m_axi_rvalid && m_axi_rready;
        if (hs_aw) aw_a = m_axi_awaddr;
        if (hs_w) begin w_d = m_axi_wdata; w_s = m_axi_wstrb; end
        if (hs_ar) ar_a = m_axi_araddr;
      end
    end
  end

  // Reference: serve the loaded queues round-robin, one whole transaction at a time.
  task automatic model_batch();
    txn_t t;
    txn_t snap [N][$];
    int sel, ptr;
    exp_id.delete(); exp_dat.delete(); exp_rsp.delete();
    ew_addr.delete(); ew_data.delete(); ew_strb.delete(); er_addr.delete();
    grant_log.delete(); grant_cyc.delete(); rsp_id.delete(); rsp_dat.delete();
    rsp_rsp.delete(); rsp_cyc.delete(); bw_addr.delete(); bw_data.delete();
    bw_strb.delete(); br_addr.delete();
    for (int i = 0; i < N; i++) snap[i] = txq[i];
    ptr = ref_last;
    do begin
      sel = -1;
      for (int k = 1; k <= N; k++)
        if (sel < 0 && snap[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
      if (sel >= 0) begin
        t = snap[sel].pop_front();
        ptr = sel;
        exp_id.push_back(sel);
        if (t.wr) begin
          for (int b = 0; b < SW; b++)
            if (t.strb[b]) ref_mem[t.addr][8*b +: 8] = t.data[8*b +: 8];
          exp_dat.push_back('0); exp_rsp.push_back(slave_bresp);
          ew_addr.push_back(t.addr); ew_data.push_back(t.data); ew_strb.push_back(t.strb);
        end else begin
          exp_dat.push_back(ref_mem[t.addr]); exp_rsp.push_back(3'b000);
          er_addr.push_back(t.addr);
        end
      end
    end while (sel >= 0);
    ref_last = ptr;
  endtask

  task automatic wait_batch(input string tag, input bit check_lat, input int viol0);
    int budget;
    budget = 0;
    while (rsp_id.size() < exp_id.size() && budget < 400) begin @(negedge clk); budget++; end
    repeat (8) @(negedge clk);
    n_checks++;
    if (rsp_id.size() != exp_id.size()) begin
      n_fail++; $display("FAIL %s rsp_count: got %0d expected %0d", tag, rsp_id.size(), exp_id.size());
    end
    n_checks++;
    if (grant_log.size() != exp_id.size()) begin
      n_fail++; $display("FAIL %s grant_count: got %0d expected %0d", tag, grant_log.size(), exp_id.size());
    end
    for (int k = 0; k < exp_id.size(); k++) begin
      if (k < grant_log.size()) begin
        n_checks++;
        if (grant_log[k] !== exp_id[k]) begin
          n_fail++; $display("FAIL %s grant[%0d]: got %0d expected %0d", tag, k, grant_log[k], exp_id[k]);
        end
      end
      if (k < rsp_id.size()) begin
        n_checks += 3;
        if (rsp_id[k] !== exp_id[k]) begin
          n_fail++; $display("FAIL %s rsp_id[%0d]: got %0d expected %0d", tag, k, rsp_id[k], exp_id[k]);
        end
        if (rsp_dat[k] !== exp_dat[k]) begin
          n_fail++; $display("FAIL %s rsp_rdata[%0d]: got %0h expected %0h", tag, k, rsp_dat[k], exp_dat[k]);
        end
        if (rsp_rsp[k] !== exp_rsp[k]) begin
          n_fail++; $display("FAIL %s rsp_resp[%0d]: got %0h expected %0h", tag, k, rsp_rsp[k], exp_rsp[k]);
        end
        if (check_lat && k < grant_cyc.size()) begin
          n_checks++;
          if (rsp_cyc[k] - grant_cyc[k] !== 3) begin
            n_fail++; $display("FAIL %s latency[%0d]: got %0d expected 3", tag, k, rsp_cyc[k] - grant_cyc[k]);
          end
        end
      end
    end
    n_checks += 2;
    if (bw_addr.size() != ew_addr.size()) begin
      n_fail++; $display("FAIL %s bus_writes: got %0d expected %0d", tag, bw_addr.size(), ew_addr.size());
    end
    if (br_addr.size() != er_addr.size()) begin
      n_fail++; $display("FAIL %s bus_reads: got %0d expected %0d", tag, br_addr.size(), er_addr.size());
    end
    for (int k = 0; k < ew_addr.size() && k < bw_addr.size(); k++) begin
      n_checks++;
      if ({bw_addr[k], bw_data[k], bw_strb[k]} !== {ew_addr[k], ew_data[k], ew_strb[k]}) begin
        n_fail++; $display("FAIL %s bus_write[%0d]: got %0h/%0h/%0h expected %0h/%0h/%0h", tag, k,
                           bw_addr[k], bw_data[k], bw_strb[k], ew_addr[k], ew_data[k], ew_strb[k]);
      end
    end
    for (int k = 0; k < er_addr.size() && k < br_addr.size(); k++) begin
      n_checks++;
      if (br_addr[k] !== er_addr[k]) begin
        n_fail++; $display("FAIL %s bus_araddr[%0d]: got %0h expected %0h", tag, k, br_addr[k], er_addr[k]);
      end
    end
    n_checks++;
    if (viol - viol0 !== 0) begin
      n_fail++; $display("FAIL %s handshake_protocol: got %0d violations expected 0", tag, viol - viol0);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.strb = s;
    return t;
  endfunction

  task automatic check_idle_outputs(input string tag);
    n_checks += 4;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
      n_fail++; $display("FAIL %s axi_ctrl: got %b expected 00000", tag,
                         {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
    end
    if ({rsp_valid, req_ready} !== '0) begin
      n_fail++; $display("FAIL %s rsp_valid/req_ready: got %b expected 0", tag, {rsp_valid, req_ready});
    end
    if ({rsp_rdata, rsp_resp} !== '0) begin
      n_fail++; $display("FAIL %s rsp_data/resp: got %0h expected 0", tag, {rsp_rdata, rsp_resp});
    end
    if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== '0) begin
      n_fail++; $display("FAIL %s addr/data regs: got %0h expected 0", tag, {m_axi_awaddr, m_axi_wdata, m_axi_wstrb});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;
    ref_last = N - 1;
  endtask

  task automatic test_write_read();
    int v0;
    @(posedge clk); #2;
    v0 = viol;
    txq[0].push_back(mk(1'b1, 8'h00, 32'd25, 4'hF));
    model_batch();
    wait_batch("write0", 1'b1, v0);
    @(posedge clk); #2;
    v0 = viol;
    txq[1].push_back(mk(1'b0, 8'h00, 32'd0, 4'h0));
    model_batch();
    wait_batch("read1", 1'b1, v0);
  endtask

  task automatic test_back_to_back();
    int v0;
    @(posedge clk); #2;
    v0 = viol;
    for (int k = 0; k < 4; k++) begin
      txq[0].push_back(mk(1'b1, AW'(8'h10 + k), $urandom, 4'hF));
      txq[1].push_back(mk(1'b0, AW'(8'h10 + k), 32'd0, 4'h0));
    end
    model_batch();
    wait_batch("back_to_back", 1'b1, v0);
  endtask

  task automatic test_aw_stall();
    int v0, a0, w0, i0;
    @(posedge clk); #2;
    v0 = viol; a0 = aw_hi; w0 = w_hi; i0 = instab;
    aw_delay = 3;
    txq[0].push_back(mk(1'b1, 8'h04, 32'hA5A5_1234, 4'hF));
    model_batch();
    wait_batch("aw_stall", 1'b0, v0);
    aw_delay = 0;
    n_checks += 3;
    if (aw_hi - a0 !== 4) begin
      n_fail++; $display("FAIL aw_stall awvalid_cycles: got %0d expected 4", aw_hi - a0);
    end
    if (w_hi - w0 !== 1) begin
      n_fail++; $display("FAIL aw_stall wvalid_cycles: got %0d expected 1", w_hi - w0);
    end
    if (instab - i0 !== 0) begin
      n_fail++; $display("FAIL aw_stall awaddr_stable: got %0d changes expected 0", instab - i0);
    end
  endtask

  task automatic test_bresp_err();
    int v0;
    @(posedge clk); #2;
    v0 = viol;
    slave_bresp = 3'b010;
    txq[1].push_back(mk(1'b1, 8'h08, 32'h0000_BEEF, 4'h3));
    model_batch();
    wait_batch("bresp_err", 1'b1, v0);
    slave_bresp = 3'b000;
  endtask

  task automatic test_reset_midread();
    int budget, v0;
    @(posedge clk); #2;
    r_delay = 20;
    txq[0].push_back(mk(1'b0, 8'h00, 32'd0, 4'h0));
    budget = 0;
    while (m_axi_rready !== 1'b1 && budget < 20) begin @(negedge clk); #1; budget++; end
    n_checks++;
    if (m_axi_rready !== 1'b1) begin
      n_fail++; $display("FAIL midread reach_rd_data: got rready=%b expected 1", m_axi_rready);
    end
    #2 rst = 1'b1;
    #1 check_idle_outputs("midread_reset");
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) txq[i].delete();
    r_delay = 0;
    ref_last = N - 1;
    rst = 1'b0;
    @(posedge clk); #2;
    v0 = viol;
    txq[1].push_back(mk(1'b1, 8'h20, 32'h1111_2222, 4'hF));
    txq[0].push_back(mk(1'b0, 8'h00, 32'd0, 4'h0));
    model_batch();
    wait_batch("after_reset_priority", 1'b1, v0);
  endtask

  task automatic test_random();
    int v0, cnt, total;
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #2;
      v0 = viol;
      aw_delay = $urandom_range(0, 2);
      w_delay  = $urandom_range(0, 2);
      r_delay  = $urandom_range(0, 2);
      slave_bresp = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000;
      total = 0;
      for (int i = 0; i < N; i++) begin
        cnt = $urandom_range(0, 3);
        for (int j = 0; j < cnt; j++)
          txq[i].push_back(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                              SW'($urandom_range(1, 15))));
        total += cnt;
      end
      if (total == 0) txq[1].push_back(mk(1'b0, 8'h03, 32'd0, 4'h0));
      model_batch();
      wait_batch($sformatf("random%0d", r), (aw_delay == 0 && w_delay == 0 && r_delay == 0), v0);
    end
    aw_delay = 0; w_delay = 0; r_delay = 0; slave_bresp = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ref_last = N - 1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_aw_stall();
    test_bresp_err();
    test_reset_midread();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
